// File: rtl/branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// branch_predictor_bht
//
// Fetch-stage branch predictor. It decodes the fetched instruction and
// combinationally decides whether fetch must be redirected. In dynamic mode the
// decision for conditional branches comes from a branch history table of 2-bit
// saturating counters. Resolved branches train the table. Two counters record
// how many branches resolved and how many of them were mispredicted.
//
// Parameters
//   SIZE       instruction and PC width (must exceed log2(ENTRIES)+2 and 7)
//   ENTRIES    number of BHT counters, power of two, at least 2
//   MODE       0 = static (every B-type predicted taken), 1 = dynamic (BHT)
//   CNT_WIDTH  width of the statistics counters
//
// Ports
//   clk                rising-edge clock
//   rst_n              asynchronous active-low reset
//   instruction        fetched instruction
//   pc                 PC of the fetched instruction
//   update_valid       a resolved B-type instruction is reported this cycle
//   update_pc          PC of the resolved branch
//   update_taken       actual branch outcome
//   update_mispredict  the prediction for the resolved branch was wrong
//   jump               redirect fetch (JAL, or B-type predicted taken)
//   jalr               fetched instruction is JALR
//   branch_count       number of resolved branches, saturating
//   mispredict_count   number of mispredicted branches, saturating
// -----------------------------------------------------------------------------
module branch_predictor_bht #(
  parameter int SIZE      = 32,
  parameter int ENTRIES   = 64,
  parameter int MODE      = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SIZE-1:0]      instruction,
  input  logic [SIZE-1:0]      pc,
  input  logic                 update_valid,
  input  logic [SIZE-1:0]      update_pc,
  input  logic                 update_taken,
  input  logic                 update_mispredict,
  output logic                 jump,
  output logic                 jalr,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  // Word-aligned PCs: bits [1:0] never carry information, so the table index
  // starts at bit 2.
  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [6:0] {
    OP_JAL    = 7'b1101111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111
  } opcode_e;

  // 2-bit saturating counter encoding. The MSB is the prediction.
  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  logic predict_taken;

  // ---------------------------------------------------------------------------
  // Decode and redirect. Purely combinational, so the prediction is available
  // in the same cycle as the fetch, including while reset is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a value unassigned and infer a latch.
    jump = 1'b0;
    jalr = 1'b0;
    // The case items match exactly, so an X/Z opcode matches none of them and
    // takes the default path, leaving both outputs at 0.
    case (instruction[6:0])
      OP_JAL:    jump = 1'b1;
      OP_BRANCH: jump = predict_taken;
      OP_JALR:   jalr = 1'b1;
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Prediction source
  // ---------------------------------------------------------------------------
  if (MODE == 0) begin : g_static

    // Static predictor: every conditional branch is treated as taken. The
    // table does not exist, so the lookup and training inputs are unused.
    assign predict_taken = 1'b1;

    logic unused_static;
    assign unused_static = ^{pc, update_pc, update_taken};

  end else begin : g_dynamic

    logic [1:0]       bht [ENTRIES];
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] update_idx;

    assign lookup_idx = pc[IDX_W+1:2];
    assign update_idx = update_pc[IDX_W+1:2];

    // The read is taken straight from the table with no forwarding of a
    // same-cycle update: a lookup racing an update to the same entry sees the
    // value from before that update.
    assign predict_taken = bht[lookup_idx][1];

    // Saturating step of one counter toward the observed outcome.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr,
                                            input logic       taken);
      logic [1:0] nxt;
      nxt = ctr;
      if (taken) begin
        if (ctr != CTR_STRONG_T) nxt = ctr + 2'd1;
      end else begin
        if (ctr != CTR_STRONG_NT) nxt = ctr - 2'd1;
      end
      return nxt;
    endfunction

    // NOTE: the table has an asynchronous reset of every entry, so it is built
    // from flops rather than a RAM macro; a RAM could not clear all entries at
    // once.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // Start every entry weakly-taken, matching the static policy until
        // training moves it.
        for (int i = 0; i < ENTRIES; i++) begin
          bht[i] <= CTR_WEAK_T;
        end
      end else if (update_valid) begin
        bht[update_idx] <= ctr_next(bht[update_idx], update_taken);
      end
    end

    // Only the index bits of either PC select an entry.
    logic unused_dynamic;
    assign unused_dynamic = ^{pc[SIZE-1:IDX_W+2], pc[1:0],
                              update_pc[SIZE-1:IDX_W+2], update_pc[1:0]};

  end

  // ---------------------------------------------------------------------------
  // Statistics. These run in both modes and hold at all-ones rather than wrap.
  // ---------------------------------------------------------------------------
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // NOTE: all clocked state is assigned with non-blocking assignments so that
  // every register samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (update_valid) begin
      if (branch_count != CNT_MAX) begin
        branch_count <= branch_count + CNT_ONE;
      end
      if (update_mispredict && (mispredict_count != CNT_MAX)) begin
        mispredict_count <= mispredict_count + CNT_ONE;
      end
    end
  end

  // Only the opcode field takes part in decode.
  logic unused_instruction;
  assign unused_instruction = ^instruction[SIZE-1:7];

endmodule

// File: tb/tb_branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_bht
//
// Three predictors share one stimulus stream:
//   u_dyn    dynamic, 64 entries, 16-bit statistics
//   u_c4     dynamic, 64 entries, 4-bit statistics (saturation)
//   u_static static mode, 16-bit statistics
// A behavioural model (integer counters clamped to 0..3, unbounded event totals
// clipped to the counter range) is compared against all outputs on every
// falling edge. Directed steps add literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_branch_predictor_bht;

  localparam int SIZE    = 32;
  localparam int ENTRIES = 64;

  // Upper instruction bits are non-zero so only the opcode field may matter.
  localparam logic [31:0] I_BR   = 32'hFE20_9E63;
  localparam logic [31:0] I_JAL  = 32'h7FF0_00EF & 32'hFFFF_FF80 | 32'h6F;
  localparam logic [31:0] I_JALR = 32'h0000_8067;
  localparam logic [31:0] I_ADD  = 32'h00B5_0533;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [SIZE-1:0] instruction = '0;
  logic [SIZE-1:0] pc = '0;
  logic            update_valid = 1'b0;
  logic [SIZE-1:0] update_pc = '0;
  logic            update_taken = 1'b0;
  logic            update_mispredict = 1'b0;

  logic        dyn_jump, dyn_jalr;
  logic [15:0] dyn_bc, dyn_mc;
  logic        c4_jump, c4_jalr;
  logic [3:0]  c4_bc, c4_mc;
  logic        st_jump, st_jalr;
  logic [15:0] st_bc, st_mc;

  always #5 clk = ~clk;

  branch_predictor_bht #(.SIZE(SIZE), .ENTRIES(ENTRIES), .MODE(1), .CNT_WIDTH(16)) u_dyn (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .pc(pc),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_mispredict(update_mispredict), .jump(dyn_jump), .jalr(dyn_jalr),
    .branch_count(dyn_bc), .mispredict_count(dyn_mc));

  branch_predictor_bht #(.SIZE(SIZE), .ENTRIES(ENTRIES), .MODE(1), .CNT_WIDTH(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .pc(pc),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_mispredict(update_mispredict), .jump(c4_jump), .jalr(c4_jalr),
    .branch_count(c4_bc), .mispredict_count(c4_mc));

  branch_predictor_bht #(.SIZE(SIZE), .ENTRIES(ENTRIES), .MODE(0), .CNT_WIDTH(16)) u_static (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .pc(pc),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_mispredict(update_mispredict), .jump(st_jump), .jalr(st_jalr),
    .branch_count(st_bc), .mispredict_count(st_mc));

  // ---------------------------------------------------------------------------
  // Checking bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int m_ctr [ENTRIES];   // 0..3, prediction is "value >= 2"
  int m_upd;             // resolved branches since reset, unbounded
  int m_mis;             // mispredicts since reset, unbounded

  function automatic int bht_index(input logic [31:0] a);
    return int'(a >> 2) % ENTRIES;
  endfunction

  function automatic int sat(input int n, input int w);
    int top;
    top = (1 << w) - 1;
    return (n > top) ? top : n;
  endfunction

  function automatic logic exp_jump(input logic [31:0] ins, input logic pt);
    logic [6:0] op;
    op = ins[6:0];
    return (op == 7'b1101111) || ((op == 7'b1100011) && pt);
  endfunction

  function automatic logic exp_jalr(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return op == 7'b1100111;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) m_ctr[i] <= 2;
      m_upd <= 0;
      m_mis <= 0;
    end else if (update_valid) begin
      if (update_taken)
        m_ctr[bht_index(update_pc)] <= (m_ctr[bht_index(update_pc)] < 3) ? m_ctr[bht_index(update_pc)] + 1 : 3;
      else
        m_ctr[bht_index(update_pc)] <= (m_ctr[bht_index(update_pc)] > 0) ? m_ctr[bht_index(update_pc)] - 1 : 0;
      m_upd <= m_upd + 1;
      if (update_mispredict) m_mis <= m_mis + 1;
    end
  end

  // Compare every output of every instance against the model each cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("dyn_jump", 32'(dyn_jump), 32'(exp_jump(instruction, m_ctr[bht_index(pc)] >= 2)));
      check("dyn_jalr", 32'(dyn_jalr), 32'(exp_jalr(instruction)));
      check("dyn_branch_count", 32'(dyn_bc), sat(m_upd, 16));
      check("dyn_mispredict_count", 32'(dyn_mc), sat(m_mis, 16));
      check("c4_jump", 32'(c4_jump), 32'(exp_jump(instruction, m_ctr[bht_index(pc)] >= 2)));
      check("c4_jalr", 32'(c4_jalr), 32'(exp_jalr(instruction)));
      check("c4_branch_count", 32'(c4_bc), sat(m_upd, 4));
      check("c4_mispredict_count", 32'(c4_mc), sat(m_mis, 4));
      check("st_jump", 32'(st_jump), 32'(exp_jump(instruction, 1'b1)));
      check("st_jalr", 32'(st_jalr), 32'(exp_jalr(instruction)));
      check("st_branch_count", 32'(st_bc), sat(m_upd, 16));
      check("st_mispredict_count", 32'(st_mc), sat(m_mis, 16));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change only at posedge+1 or negedge+1, never on
  // the falling edge where the compare process samples.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [31:0] a);
    instruction = ins;
    pc          = a;
  endtask

  task automatic upd(input logic [31:0] a, input logic t, input logic m);
    update_valid      = 1'b1;
    update_pc         = a;
    update_taken      = t;
    update_mispredict = m;
    step();
    update_valid      = 1'b0;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    // Reset and decode while reset is held
    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    step();
    fetch(I_BR, 32'h100);
    look();
    check("reset_br_jump", 32'(dyn_jump), 32'd1);
    check("reset_branch_count", 32'(dyn_bc), 32'd0);
    check("reset_mispredict_count", 32'(dyn_mc), 32'd0);
    step();
    rst_n = 1'b1;

    // Decode after reset
    look();
    check("br_jump", 32'(dyn_jump), 32'd1);
    step(); fetch(I_JAL, 32'h104);
    look();
    check("jal_jump", 32'(dyn_jump), 32'd1);
    step(); fetch(I_JALR, 32'h108);
    look();
    check("jalr_jalr", 32'(dyn_jalr), 32'd1);
    check("jalr_jump", 32'(dyn_jump), 32'd0);
    step(); fetch(I_ADD, 32'h10C);
    look();
    check("add_jump", 32'(dyn_jump), 32'd0);
    check("add_jalr", 32'(dyn_jalr), 32'd0);

    // Training and saturation at one entry
    step(); fetch(I_BR, 32'h100);
    upd(32'h100, 1'b0, 1'b1);
    upd(32'h100, 1'b0, 1'b1);
    look();
    check("two_nt_jump", 32'(dyn_jump), 32'd0);
    check("two_nt_static_jump", 32'(st_jump), 32'd1);
    upd(32'h100, 1'b0, 1'b0);
    look();
    check("three_nt_jump", 32'(dyn_jump), 32'd0);
    upd(32'h100, 1'b1, 1'b0);
    look();
    check("one_t_jump", 32'(dyn_jump), 32'd0);
    upd(32'h100, 1'b1, 1'b0);
    look();
    check("two_t_jump", 32'(dyn_jump), 32'd1);
    check("five_upd_branch_count", 32'(dyn_bc), 32'd5);
    check("five_upd_mispredict_count", 32'(dyn_mc), 32'd2);

    // Aliasing: 0x200 shares index 0 with 0x100, 0x104 does not
    upd(32'h100, 1'b0, 1'b0);
    upd(32'h100, 1'b0, 1'b0);
    fetch(I_BR, 32'h200);
    look();
    check("alias_jump", 32'(dyn_jump), 32'd0);
    fetch(I_BR, 32'h104);
    look();
    check("neighbour_jump", 32'(dyn_jump), 32'd1);

    // Same-cycle lookup and update: pre-update value, then the new one
    step();
    fetch(I_BR, 32'h104);
    update_valid = 1'b1; update_pc = 32'h104; update_taken = 1'b0; update_mispredict = 1'b0;
    look();
    check("same_cycle_jump", 32'(dyn_jump), 32'd1);
    step();
    update_valid = 1'b0;
    look();
    check("next_cycle_jump", 32'(dyn_jump), 32'd0);

    // Mixed traffic checked by the model only
    for (int i = 0; i < 24; i++) begin
      fetch((i % 4 == 3) ? I_JAL : I_BR, 32'(i * 36));
      upd(32'((i * 20) & 32'h1FC), (i % 3) != 0, i[0]);
      look();
    end

    // Static mode ignores training but still counts
    do_reset();
    for (int i = 0; i < 5; i++) upd(32'h100, 1'b0, 1'b0);
    fetch(I_BR, 32'h100);
    look();
    check("static_trained_jump", 32'(st_jump), 32'd1);
    check("static_branch_count", 32'(st_bc), 32'd5);
    check("dyn_trained_jump", 32'(dyn_jump), 32'd0);

    // Counter saturation and reset racing an update
    do_reset();
    for (int i = 0; i < 20; i++) upd(32'h100, 1'b0, 1'b1);
    look();
    check("c4_sat_branch_count", 32'(c4_bc), 32'd15);
    check("c4_sat_mispredict_count", 32'(c4_mc), 32'd15);
    check("dyn16_branch_count", 32'(dyn_bc), 32'd20);
    check("sat_trained_jump", 32'(dyn_jump), 32'd0);
    step();
    update_valid = 1'b1; update_pc = 32'h100; update_taken = 1'b0; update_mispredict = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_reset_branch_count", 32'(c4_bc), 32'd0);
    check("async_reset_mispredict_count", 32'(c4_mc), 32'd0);
    check("async_reset_bht_jump", 32'(dyn_jump), 32'd1);
    step();
    rst_n = 1'b1;
    update_valid = 1'b0;
    look();
    check("reset_wins_branch_count", 32'(dyn_bc), 32'd0);
    check("reset_wins_jump", 32'(dyn_jump), 32'd1);

    step();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor_bht.md
BRANCH_PREDICTOR_BHT -- requirements
Module: branch_predictor_bht

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the reset port SHALL be named rst_n and the clock port clk.
REQ-002 Parameter SIZE, default 32: instruction and PC width.
REQ-003 Parameter ENTRIES, default 64: BHT depth; power of two, minimum 2.
REQ-004 Parameter MODE, default 1: 0 = static (all B-type predicted taken), 1 = dynamic (BHT).
REQ-005 Parameter CNT_WIDTH, default 16: width of the statistics counters.
REQ-006 Port: clk, input, 1, rising-edge clock.
REQ-007 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port: instruction, input, SIZE, fetched instruction.
REQ-009 Port: pc, input, SIZE, PC of the fetched instruction.
REQ-010 Port: update_valid, input, 1, a resolved B-type instruction is reported this cycle.
REQ-011 Port: update_pc, input, SIZE, PC of the resolved branch.
REQ-012 Port: update_taken, input, 1, actual branch outcome.
REQ-013 Port: update_mispredict, input, 1, the prediction for this branch was wrong.
REQ-014 Port: jump, output, 1, redirect fetch (JAL, or B-type predicted taken).
REQ-015 Port: jalr, output, 1, instruction is JALR.
REQ-016 Port: branch_count, output, CNT_WIDTH, number of resolved branches.
REQ-017 Port: mispredict_count, output, CNT_WIDTH, number of mispredicted branches.

Function
REQ-018 Decode SHALL be combinational: J-type = opcode 7'b1101111, B-type = 7'b1100011, JALR = 7'b1100111 (opcode = instruction[6:0]).
REQ-019 jump SHALL equal J-type OR (B-type AND predict_taken), where predict_taken is computed combinationally in the same cycle (zero latency).
REQ-020 jalr SHALL be 1 exactly when the opcode is JALR, in every mode.
REQ-021 MODE=0: predict_taken SHALL be 1 constantly; the BHT SHALL be neither read nor written.
REQ-022 MODE=1: the BHT SHALL hold ENTRIES 2-bit saturating counters, indexed by pc[log2(ENTRIES)+1:2] for lookup and update_pc[log2(ENTRIES)+1:2] for update.
REQ-023 Counter states: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken; predict_taken = counter[1].
REQ-024 On a clock edge with update_valid=1, the indexed counter SHALL increment if update_taken=1 (saturating at 11) and decrement if update_taken=0 (saturating at 00).
REQ-025 A lookup and an update to the same index in the same cycle SHALL return the pre-update counter value; there is no bypass.
REQ-026 Only one update per cycle is supported; update_valid=0 SHALL leave the table unchanged.
REQ-027 branch_count SHALL increment by 1 on each edge with update_valid=1 and saturate at all-ones.
REQ-028 mispredict_count SHALL increment by 1 on each edge with update_valid=1 and update_mispredict=1, saturating at all-ones; update_mispredict is ignored when update_valid=0.
REQ-029 Statistics counters SHALL operate in both modes.
REQ-030 X/Z on instruction SHALL NOT drive jump or jalr to 1.

Reset
REQ-031 rst_n=0 SHALL asynchronously set every BHT counter to 10 (weakly-taken) and set branch_count and mispredict_count to 0.
REQ-032 During reset, jump and jalr SHALL still follow the combinational decode; B-type instructions are predicted taken.
REQ-033 A reset asserted in the same cycle as an update SHALL win: the update is discarded.

Verification
REQ-034 After reset, MODE=1, B-type at pc=0x100 -> jump=1; JAL -> jump=1; JALR -> jalr=1, jump=0; ADD opcode 0110011 -> jump=0, jalr=0.
REQ-035 Two updates, pc=0x100, taken=0 -> B-type lookup at 0x100 gives jump=0; a third not-taken update keeps the counter at 00; two taken updates -> jump=1.
REQ-036 ENTRIES=64: update pc=0x100 not-taken twice -> lookup at 0x200 (same index) gives jump=0, lookup at 0x104 gives jump=1.
REQ-037 Lookup and not-taken update at the same index in one cycle, counter at 10 -> jump=1 that cycle, jump=0 next cycle.
REQ-038 CNT_WIDTH=4: 20 updates with mispredict=1 -> branch_count=15, mispredict_count=15; assert rst_n mid-stream -> both 0 immediately, BHT back to 10.
REQ-039 MODE=0: 5 not-taken updates at pc=0x100 -> B-type at 0x100 still gives jump=1; branch_count=5.
